// File: rtl/sap_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_display_pkg
//  Description : Shared converter state, segment codes and digit count for
//                the SAP output display. OUT_DISPLAY_SIGNED_EN adds a sign digit.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_PUBLISH = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

`ifdef OUT_DISPLAY_SIGNED_EN
    localparam int NUM_DIGITS = 4;
`else
    localparam int NUM_DIGITS = 3;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_of = SEG_0;
            4'd1:    seg_of = SEG_1;
            4'd2:    seg_of = SEG_2;
            4'd3:    seg_of = SEG_3;
            4'd4:    seg_of = SEG_4;
            4'd5:    seg_of = SEG_5;
            4'd6:    seg_of = SEG_6;
            4'd7:    seg_of = SEG_7;
            4'd8:    seg_of = SEG_8;
            4'd9:    seg_of = SEG_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_display_if
//  Description : Output-register side (master) to display side (slave) bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface out_display_if;
    logic [7:0] value;
    logic       update;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    modport master (output value, output update, input seg, input an, input busy);
    modport slave  (input value, input update, output seg, output an, output busy);
endinterface
`default_nettype wire

// File: rtl/bcd_shift_conv.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_shift_conv
//  Description : Sequential shift-add-3 binary-to-BCD converter, one bit per
//                cycle; done is high for the single PUBLISH cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_shift_conv
    import sap_display_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t r_state;
    logic [7:0]  r_operand;
    logic [11:0] r_acc;
    logic [2:0]  r_bit_cnt;
    logic        r_done;
    logic [10:0] w_adj;

    // Hundreds never exceeds 2 for an 8-bit operand, so it needs no correction.
    always_comb begin
        w_adj = r_acc[10:0];
        if (r_acc[3:0] >= 4'd5) w_adj[3:0] = r_acc[3:0] + 4'd3;
        if (r_acc[7:4] >= 4'd5) w_adj[7:4] = r_acc[7:4] + 4'd3;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_operand <= '0;
            r_acc     <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_operand <= bin;
                        r_acc     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_acc     <= {w_adj, r_operand[7]};
                    r_operand <= {r_operand[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= ST_PUBLISH;
                        r_done  <= 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    if (start) begin
                        r_operand <= bin;
                        r_acc     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done = r_done;
    assign bcd  = r_acc;

endmodule
`default_nettype wire

// File: rtl/out_display.sv
`default_nettype none
// ============================================================================
//  Module      : out_display
//  Description : Decimal 4-digit multiplexed display of the SAP output register.
//                Define OUT_DISPLAY_SIGNED_EN for two's-complement with sign digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_display
    import sap_display_pkg::*;
#(
    parameter int SCAN_DIV = 4096
) (
    input  logic         clk,
    input  logic         clr,
    out_display_if.slave bus
);

    localparam int              CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [1:0]      c_idx_last = 2'(NUM_DIGITS - 1);
    localparam logic [3:0]      c_an_mask  = (NUM_DIGITS == 4) ? 4'b0000 : 4'b1000;

    logic             r_busy;
    logic             r_pend;
    logic [7:0]       r_hold;
    logic [3:0]       r_hund, r_tens, r_units;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_scan_idx;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic        w_accept, w_restart, w_start, w_done;
    logic [7:0]  w_raw, w_operand;
    logic [11:0] w_bcd;
    logic        w_hund_blank, w_tens_blank;
    logic [6:0]  w_sign_seg, w_seg_next;
    logic [3:0]  w_an_next;

    // An update coinciding with PUBLISH is treated as pending and restarts directly.
    assign w_accept  = bus.update && !r_busy;
    assign w_restart = w_done && (r_pend || bus.update);
    assign w_start   = w_accept || w_restart;
    assign w_raw     = bus.update ? bus.value : r_hold;

`ifdef OUT_DISPLAY_SIGNED_EN
    logic r_sign_cap, r_neg;

    assign w_operand  = w_raw[7] ? (8'd0 - w_raw) : w_raw;
    assign w_sign_seg = r_neg ? SEG_MINUS : SEG_BLANK;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sign_cap <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            if (w_start) r_sign_cap <= w_raw[7];
            if (w_done)  r_neg      <= r_sign_cap;
        end
    end
`else
    assign w_operand  = w_raw;
    assign w_sign_seg = SEG_BLANK;
`endif

    bcd_shift_conv u_conv (
        .clk   (clk),
        .clr   (clr),
        .start (w_start),
        .bin   (w_operand),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
            r_hold  <= '0;
            r_hund  <= '0;
            r_tens  <= '0;
            r_units <= '0;
        end else begin
            if (w_start)     r_busy <= 1'b1;
            else if (w_done) r_busy <= 1'b0;

            if (w_restart) begin
                r_pend <= 1'b0;
            end else if (bus.update && r_busy) begin
                r_pend <= 1'b1;
                r_hold <= bus.value;
            end

            if (w_done) begin
                r_hund  <= w_bcd[11:8];
                r_tens  <= w_bcd[7:4];
                r_units <= w_bcd[3:0];
            end
        end
    end

    always_comb begin
        w_hund_blank = (r_hund == 4'd0);
        w_tens_blank = w_hund_blank && (r_tens == 4'd0);
        case (r_scan_idx)
            2'd0:    w_seg_next = seg_of(r_units);
            2'd1:    w_seg_next = w_tens_blank ? SEG_BLANK : seg_of(r_tens);
            2'd2:    w_seg_next = w_hund_blank ? SEG_BLANK : seg_of(r_hund);
            default: w_seg_next = w_sign_seg;
        endcase
        w_an_next = ~(4'b0001 << r_scan_idx) | c_an_mask;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_an       <= 4'b1111;
            r_seg      <= SEG_BLANK;
        end else begin
            if (r_scan_cnt == c_cnt_last) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == c_idx_last) ? 2'd0 : r_scan_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + CNT_W'(1);
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
    assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: doc/out_display.md
# out_display

Downstream consumer of the SAP output register: converts the 8-bit `out` value into decimal and drives a multiplexed 4-digit common-anode seven-segment display. A strobe from the output-register load path starts a sequential binary-to-BCD conversion (shift-add-3, one bit per cycle). The display keeps scanning the last completed result, so the visible value never shows a half-converted number.

## Interface
- `SCAN_DIV`, 4096: clock cycles each digit stays enabled; legal range ≥1.
- `clk` input 1: single system clock, rising edge.
- `clr` input 1: asynchronous, active-high reset.
- `value` input 8: output-register contents; sampled only on `update`.
- `update` input 1: one-cycle strobe; high in the cycle after the output register loads.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-high.
- `an` output 4: digit enables, active-low; an[0] units, an[1] tens, an[2] hundreds, an[3] sign.
- `busy` output 1: high while a conversion is in flight.

## Operation
- Converter FSM states: IDLE, SHIFT, PUBLISH.
  - IDLE: on `update`, capture `value` into the operand, clear the BCD accumulator and the bit counter, then go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble ≥5, then shift the operand MSB into the accumulator. Leave after the 8th shift.
  - PUBLISH: copy hundreds, tens and units into the display registers, then return to IDLE.
- Pending request: `update` arriving in SHIFT or PUBLISH sets a single pending flag and stores `value` in a holding register. A later `update` overwrites the held value (last value wins). PUBLISH with the flag set goes straight back to SHIFT using the held value and clears the flag.
- Digit encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, minus=40, blank=00.
- Leading-zero blanking:
  - Hundreds is blank if it is 0.
  - Tens is blank if hundreds and tens are both 0.
  - Units is always shown.
- Scan:
  - The digit index advances 0→1→2→3→0 every SCAN_DIV cycles; 0→1→2→0 when the sign feature is compiled out.
  - `an` and `seg` are registered from the current index and the display registers.

## Timing
- Reset state:
  - FSM in IDLE, pending flag 0.
  - Display registers 0, scan index 0, scan counter 0.
  - `busy`=0, `an`=4'b1111, `seg`=7'h00.
- First edge after `clr` falls: `an`=4'b1110, `seg`=7'h3F.
- Conversion latency:
  - `update` sampled at edge N with the FSM in IDLE.
  - Shifts occur at edges N+1 to N+8; PUBLISH occurs at edge N+9.
  - New digit values appear on `seg` from edge N+10.
  - `busy` is high after edge N and low after edge N+9, unless a pending request exists, in which case it stays high.
- `update` in the same cycle as PUBLISH counts as pending.
- `clr` asserted mid-conversion: the conversion is aborted, the display returns to 0, and `busy` drops immediately.
- The scan counter wraps at SCAN_DIV−1 and runs independently of the converter.

## Configuration
- `OUT_DISPLAY_SIGNED_EN`
  - Defined: `value` is treated as two's complement. The operand captured is the magnitude, computed as (value[7] ? −value : value) in 8 bits, so 8'h80 gives 128. The sign flag is latched at capture and published together with the digits. Digit 3 shows minus (40) when negative, blank otherwise.
  - Undefined: `value` is unsigned 0–255. Only three digits are scanned, and an[3] is held at 1.

## Structure
- Shared package `sap_display_pkg` holds:
  - the converter state enum;
  - the segment constants SEG_0 to SEG_9, SEG_MINUS and SEG_BLANK;
  - NUM_DIGITS.
- Sub-module `bcd_shift_conv`: the sequential shift-add-3 converter, with ports clk, clr, start, bin[7:0], done, bcd[11:0].
- `out_display` keeps the pending logic, the scan counter and the seven-segment decode.

## Test plan
- Reset, then release `clr` → `busy`=0, and the first edge gives an=1110, seg=3F. Over three scan periods, tens and hundreds show blank (00).
- update with value=255 at edge N → `busy` high for edges N+1 to N+9. From N+10 the scan shows an=1110/6D, 1101/6D, 1011/5B.
- value=7 → units 07, tens 00, hundreds 00. value=100 → 3F, 3F, 06.
- update 42, then update 199 three cycles later, then update 13 one cycle after that → display shows 42 after 10 cycles, then 13 exactly 9 cycles later. 199 never appears.
- `clr` pulsed at the 4th shift of value=200 → `busy` goes to 0 at once. Display shows 0. No later publish occurs.
- With `OUT_DISPLAY_SIGNED_EN` defined:
  - 8'h80 → sign 40, digits 1, 2, 8.
  - 8'hFF → sign 40, units 06, tens and hundreds blank.
  - 8'h05 → sign 00.
